// File: rtl/medidor_eco_pkg.sv
// Shared types and helpers for the ultrasonic echo meter: FSM state codes,
// BCD geometry and the saturating 3-digit BCD increment.
package medidor_eco_pkg;

    localparam int          BCD_W   = 4;
    localparam int          N_DIG   = 3;
    localparam logic [11:0] BCD_MAX = 12'h999;

    typedef enum logic [2:0] {
        INICIAL     = 3'd0,
        ESPERA_ECHO = 3'd1,
        MEDIDA      = 3'd2,
        ARMAZENA    = 3'd3,
        FINAL       = 3'd4,
        ERRO        = 3'd5
    } estado_t;

    // Decimal-carry increment that sticks at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        logic        carry;
        r     = v;
        carry = (v != BCD_MAX);
        for (int i = 0; i < N_DIG; i++) begin
            if (carry) begin
                if (r[i*BCD_W +: BCD_W] == 4'd9) begin
                    r[i*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/contador_bcd_3dig.sv
// Three-digit BCD counter, synchronous clear, saturating at 999.
module contador_bcd_3dig
    import medidor_eco_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        zera,
    input  logic        conta,
    output logic [11:0] bcd
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            bcd <= 12'h000;
        else if (zera)
            bcd <= 12'h000;
        else if (conta)
            bcd <= bcd_inc(bcd);
    end

endmodule

// File: rtl/medidor_eco.sv
// Echo-width meter: times the synchronized echo pulse, converts to rounded
// centimetres in BCD, strobes pronto on completion and flags echo loss.
module medidor_eco
    import medidor_eco_pkg::*;
#(
    parameter int CICLOS_CM      = 2941,
    parameter int TIMEOUT_CICLOS = 1250000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic [11:0] distancia,
    output logic        pronto,
    output logic        timeout,
    output logic [2:0]  db_estado
);

    localparam logic [31:0] CM_MAX  = 32'(CICLOS_CM - 1);
    localparam logic [31:0] CM_MEIO = 32'(CICLOS_CM / 2);
    localparam logic [31:0] TO_MAX  = 32'(TIMEOUT_CICLOS - 1);

    estado_t     estado;
    logic        echo_m, echo_s;
    logic [31:0] cnt_cm, cnt_to;
    logic [11:0] bcd;
    logic        bcd_zera, bcd_conta;
    logic        arred, cm_wrap;

    assign db_estado = estado;
    assign arred     = (cnt_cm >= CM_MEIO);
    // >= rather than == lets CICLOS_CM=1 work with the detect cycle preloading 1
    assign cm_wrap   = (cnt_cm >= CM_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
        end
    end

    always_comb begin
        bcd_zera  = 1'b0;
        bcd_conta = 1'b0;
        case (estado)
            INICIAL:     bcd_zera  = 1'b1;
            ESPERA_ECHO: bcd_zera  = echo_s;
            MEDIDA:      bcd_conta = echo_s && cm_wrap;
            ARMAZENA:    bcd_conta = arred;
            default:     ;
        endcase
    end

    contador_bcd_3dig u_bcd (
        .clock (clock),
        .reset (reset),
        .zera  (bcd_zera),
        .conta (bcd_conta),
        .bcd   (bcd)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= INICIAL;
            cnt_cm    <= '0;
            cnt_to    <= '0;
            distancia <= 12'h000;
            pronto    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                INICIAL: begin
                    cnt_cm <= '0;
                    cnt_to <= '0;
                    if (medir) begin
                        estado  <= ESPERA_ECHO;
                        timeout <= 1'b0;
                    end
                end
                ESPERA_ECHO: begin
                    if (echo_s) begin
                        estado <= MEDIDA;
                        cnt_to <= '0;
                        cnt_cm <= 32'd1;
                    end else if (cnt_to == TO_MAX) begin
                        estado  <= ERRO;
                        timeout <= 1'b1;
                        pronto  <= 1'b1;
                    end else begin
                        cnt_to <= cnt_to + 32'd1;
                    end
                end
                MEDIDA: begin
                    if (!echo_s) begin
                        estado <= ARMAZENA;
                    end else if (cnt_to == TO_MAX) begin
                        estado  <= ERRO;
                        timeout <= 1'b1;
                        pronto  <= 1'b1;
                    end else begin
                        cnt_to <= cnt_to + 32'd1;
                        cnt_cm <= cm_wrap ? 32'd0 : cnt_cm + 32'd1;
                    end
                end
                ARMAZENA: begin
                    // the counter rounds on this same edge; load its next value directly
                    distancia <= arred ? bcd_inc(bcd) : bcd;
                    pronto    <= 1'b1;
                    estado    <= FINAL;
                end
                FINAL:   estado <= INICIAL;
                ERRO:    estado <= INICIAL;
                default: estado <= INICIAL;
            endcase
        end
    end

endmodule

// File: tb/tb_medidor_eco.sv
// Bench for medidor_eco: two instances (A: 10 cyc/cm, timeout 200; B: 1 cyc/cm,
// timeout 2000) with a per-instance scoreboard popped on each pronto strobe.
module tb_medidor_eco;

    typedef struct packed {
        logic [11:0] d;
        logic        t;
    } esp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        medir_a = 1'b0, echo_a = 1'b0, medir_b = 1'b0, echo_b = 1'b0;
    logic [11:0] dist_a, dist_b;
    logic        pronto_a, pronto_b, to_a, to_b;
    logic [2:0]  est_a, est_b;

    int   n_cmp = 0;
    int   n_err = 0;
    int   pcnt_a = 0;
    int   pcnt_b = 0;
    esp_t q_a[$];
    esp_t q_b[$];

    always #5 clock = ~clock;

    medidor_eco #(.CICLOS_CM(10), .TIMEOUT_CICLOS(200)) dut_a (
        .clock(clock), .reset(reset), .medir(medir_a), .echo(echo_a),
        .distancia(dist_a), .pronto(pronto_a), .timeout(to_a), .db_estado(est_a)
    );

    medidor_eco #(.CICLOS_CM(1), .TIMEOUT_CICLOS(2000)) dut_b (
        .clock(clock), .reset(reset), .medir(medir_b), .echo(echo_b),
        .distancia(dist_b), .pronto(pronto_b), .timeout(to_b), .db_estado(est_b)
    );

    always @(negedge clock) begin
        if (pronto_a) begin
            esp_t e;
            pcnt_a++;
            n_cmp++;
            if (q_a.size() == 0) begin
                n_err++;
                $display("FAIL sb_a: unexpected pronto, distancia=%h timeout=%b", dist_a, to_a);
            end else begin
                e = q_a.pop_front();
                if ({dist_a, to_a} !== e) begin
                    n_err++;
                    $display("FAIL sb_a: distancia=%h timeout=%b, expected %h %b", dist_a, to_a, e.d, e.t);
                end
            end
        end
        if (pronto_b) begin
            esp_t e;
            pcnt_b++;
            n_cmp++;
            if (q_b.size() == 0) begin
                n_err++;
                $display("FAIL sb_b: unexpected pronto, distancia=%h timeout=%b", dist_b, to_b);
            end else begin
                e = q_b.pop_front();
                if ({dist_b, to_b} !== e) begin
                    n_err++;
                    $display("FAIL sb_b: distancia=%h timeout=%b, expected %h %b", dist_b, to_b, e.d, e.t);
                end
            end
        end
    end

    task automatic ciclos(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulso_medir(input bit b);
        @(negedge clock);
        if (b) medir_b = 1'b1; else medir_a = 1'b1;
        @(negedge clock);
        medir_a = 1'b0;
        medir_b = 1'b0;
    endtask

    task automatic pulso_echo(input bit b, input int w);
        if (b) echo_b = 1'b1; else echo_a = 1'b1;
        ciclos(w);
        echo_a = 1'b0;
        echo_b = 1'b0;
    endtask

    // Waits for pronto at successive negedges; k = negedges elapsed.
    task automatic espera_pronto(input bit b, input int lim, output int k);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!(b ? pronto_b : pronto_a) && k < lim);
        n_cmp++;
        if (!(b ? pronto_b : pronto_a)) begin
            n_err++;
            $display("FAIL pronto_wait_%s: no pronto within %0d cycles", b ? "b" : "a", lim);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        ciclos(3);
        reset = 1'b0;
        ciclos(5);
        n_cmp += 8;
        if (dist_a !== 12'h000) begin n_err++; $display("FAIL rst_dist_a: %h vs 000", dist_a); end
        if (pronto_a !== 1'b0)  begin n_err++; $display("FAIL rst_pronto_a: %b vs 0", pronto_a); end
        if (to_a !== 1'b0)      begin n_err++; $display("FAIL rst_to_a: %b vs 0", to_a); end
        if (est_a !== 3'd0)     begin n_err++; $display("FAIL rst_est_a: %0d vs 0", est_a); end
        if (dist_b !== 12'h000) begin n_err++; $display("FAIL rst_dist_b: %h vs 000", dist_b); end
        if (pronto_b !== 1'b0)  begin n_err++; $display("FAIL rst_pronto_b: %b vs 0", pronto_b); end
        if (to_b !== 1'b0)      begin n_err++; $display("FAIL rst_to_b: %b vs 0", to_b); end
        if (est_b !== 3'd0)     begin n_err++; $display("FAIL rst_est_b: %0d vs 0", est_b); end
    endtask

    task automatic test_medida;
        int k;
        // 125 cycles = 12.5 cm rounds up; 124 = 12.4 cm rounds down
        q_a.push_back('{12'h013, 1'b0});
        pulso_medir(0);
        n_cmp++;
        if (est_a !== 3'd1) begin n_err++; $display("FAIL espera_state: %0d vs 1", est_a); end
        ciclos(20);
        pulso_echo(0, 125);
        espera_pronto(0, 50, k);
        n_cmp++;
        if (k != 4) begin n_err++; $display("FAIL pronto_latency: %0d cycles vs 4", k); end
        ciclos(5);
        q_a.push_back('{12'h012, 1'b0});
        pulso_medir(0);
        ciclos(20);
        pulso_echo(0, 124);
        espera_pronto(0, 50, k);
        ciclos(5);
    endtask

    task automatic test_timeout;
        int k;
        q_a.push_back('{12'h012, 1'b1});
        pulso_medir(0);
        espera_pronto(0, 400, k);
        n_cmp++;
        if (k != 200) begin n_err++; $display("FAIL timeout_latency: %0d cycles vs 200", k); end
        ciclos(10);
        n_cmp += 2;
        if (to_a !== 1'b1)      begin n_err++; $display("FAIL timeout_sticky: %b vs 1", to_a); end
        if (dist_a !== 12'h012) begin n_err++; $display("FAIL timeout_dist_hold: %h vs 012", dist_a); end
        q_a.push_back('{12'h013, 1'b0});
        pulso_medir(0);
        n_cmp++;
        if (to_a !== 1'b0) begin n_err++; $display("FAIL timeout_clear: %b vs 0", to_a); end
        ciclos(5);
        pulso_echo(0, 125);
        espera_pronto(0, 50, k);
        ciclos(5);
    endtask

    task automatic test_saturacao;
        int k;
        q_b.push_back('{12'h999, 1'b0});
        pulso_medir(1);
        ciclos(10);
        pulso_echo(1, 1500);
        espera_pronto(1, 50, k);
        ciclos(5);
    endtask

    task automatic test_reset_meio;
        int k, p0;
        p0 = pcnt_a;
        pulso_medir(0);
        ciclos(20);
        echo_a = 1'b1;
        ciclos(30);
        reset = 1'b1;
        #1;
        n_cmp += 4;
        if (est_a !== 3'd0)     begin n_err++; $display("FAIL midrst_est: %0d vs 0", est_a); end
        if (dist_a !== 12'h000) begin n_err++; $display("FAIL midrst_dist: %h vs 000", dist_a); end
        if (to_a !== 1'b0)      begin n_err++; $display("FAIL midrst_to: %b vs 0", to_a); end
        if (dist_b !== 12'h000) begin n_err++; $display("FAIL midrst_dist_b: %h vs 000", dist_b); end
        @(negedge clock);
        reset = 1'b0;
        ciclos(30);
        echo_a = 1'b0;
        ciclos(20);
        n_cmp++;
        if (pcnt_a != p0) begin n_err++; $display("FAIL midrst_no_pronto: %0d pulses vs 0", pcnt_a - p0); end
        q_a.push_back('{12'h004, 1'b0});
        pulso_medir(0);
        ciclos(10);
        pulso_echo(0, 40);
        espera_pronto(0, 50, k);
        ciclos(5);
    endtask

    task automatic test_back_to_back;
        int k, p0;
        p0 = pcnt_a;
        q_a.push_back('{12'h004, 1'b0});
        q_a.push_back('{12'h013, 1'b0});
        @(negedge clock);
        medir_a = 1'b1;
        ciclos(10);
        pulso_echo(0, 40);
        espera_pronto(0, 50, k);
        ciclos(10);
        n_cmp++;
        if (est_a !== 3'd1) begin n_err++; $display("FAIL b2b_rearm: state %0d vs 1", est_a); end
        pulso_echo(0, 125);
        espera_pronto(0, 50, k);
        medir_a = 1'b0;
        ciclos(250);
        n_cmp++;
        if (pcnt_a - p0 != 2) begin n_err++; $display("FAIL b2b_pronto_count: %0d vs 2", pcnt_a - p0); end
    endtask

    initial begin
        test_reset();
        test_medida();
        test_timeout();
        test_saturacao();
        test_reset_meio();
        test_back_to_back();
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d/%0d left vs 0/0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
